// File: rtl/apb_fir_ctrl_slave.sv
// APB front-end for the FIR filter: register file, coefficient RAM and a one-wait-state
// coefficient read path. The RAM read port is shared with the FIR datapath while busy.
module apb_fir_ctrl_slave #(
  parameter int  DATA_W   = 16,
  parameter int  NUM_COEF = 32,
  parameter int  SAMP_W   = 14,
  localparam int CA_W     = $clog2(NUM_COEF)
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [31:0]       PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic              PREADY,
  output logic [31:0]       PRDATA,
  output logic              PSLVERR,
  output logic              start,
  input  logic              busy,
  input  logic              done,
  output logic              irq,
  input  logic [CA_W-1:0]   fir_coef_addr,
  output logic [DATA_W-1:0] fir_coef_data,
  output logic [CA_W:0]     num_coef,
  output logic [SAMP_W-1:0] num_samples
);

  // state    | meaning
  // S_IDLE   | no coefficient read outstanding; regs/writes/errors complete here
  // S_RD_WAIT| RAM data for an APB coefficient read is on ram_q; complete the read
  typedef enum logic {S_IDLE, S_RD_WAIT} state_e;

  localparam int          NC_W      = CA_W + 1;
  localparam logic [31:0] COEF_BASE = 32'h100;
  localparam logic [31:0] COEF_END  = COEF_BASE + 32'(4 * NUM_COEF);
  localparam logic [31:0] DATA_MASK = (DATA_W >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << DATA_W) - 32'd1);

  state_e              state_q, state_d;
  logic                start_q, irq_en_q, done_q, irq_q;
  logic [CA_W:0]       ncoef_q;
  logic [SAMP_W-1:0]   nsamp_q;
  logic [DATA_W-1:0]   mem [NUM_COEF];
  logic [DATA_W-1:0]   ram_q;

  logic                access;
  logic                hit_ctrl, hit_stat, hit_ncoef, hit_nsamp, hit_coef, hit_any;
  logic                err;
  logic [31:0]         wdata;
  logic [CA_W-1:0]     apb_idx, ram_raddr;
  logic [31:0]         reg_rdata;
  logic                pready_c, pslverr_c;
  logic [31:0]         prdata_c;
  logic                reg_we, coef_we;

  assign access    = PSEL & PENABLE;
  assign wdata     = PWDATA & DATA_MASK;
  assign hit_ctrl  = (PADDR == 32'h00);
  assign hit_stat  = (PADDR == 32'h04);
  assign hit_ncoef = (PADDR == 32'h08);
  assign hit_nsamp = (PADDR == 32'h0C);
  assign hit_coef  = (PADDR >= COEF_BASE) && (PADDR < COEF_END) && (PADDR[1:0] == 2'b00);
  assign hit_any   = hit_ctrl | hit_stat | hit_ncoef | hit_nsamp | hit_coef;
  assign apb_idx   = CA_W'((PADDR - COEF_BASE) >> 2);
  assign ram_raddr = busy ? fir_coef_addr : apb_idx;

  // Any error completes immediately and suppresses every side effect of the access.
  assign err = ~hit_any
             | (hit_coef & busy)
             | (PWRITE & hit_ctrl & PWDATA[0] & busy)
             | (PWRITE & hit_ncoef & (wdata > 32'(NUM_COEF)));

  always_comb begin
    reg_rdata = '0;
    if (hit_ctrl)       reg_rdata = {30'd0, irq_en_q, 1'b0};
    else if (hit_stat)  reg_rdata = {30'd0, done_q, busy};
    else if (hit_ncoef) reg_rdata = 32'(ncoef_q);
    else if (hit_nsamp) reg_rdata = 32'(nsamp_q);
  end

  always_comb begin
    state_d   = state_q;
    pready_c  = 1'b0;
    pslverr_c = 1'b0;
    prdata_c  = '0;
    reg_we    = 1'b0;
    coef_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          if (err) begin
            pready_c  = 1'b1;
            pslverr_c = 1'b1;
          end else if (hit_coef && !PWRITE) begin
            state_d = S_RD_WAIT;
          end else begin
            pready_c = 1'b1;
            if (PWRITE) begin
              reg_we  = ~hit_coef;
              coef_we = hit_coef;
            end else begin
              prdata_c = reg_rdata;
            end
          end
        end
      end
      S_RD_WAIT: begin
        state_d  = S_IDLE;
        pready_c = 1'b1;
        prdata_c = 32'(ram_q);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      ncoef_q  <= '0;
      nsamp_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= reg_we & hit_ctrl & PWDATA[0];
      if (reg_we && hit_ctrl)  irq_en_q <= PWDATA[1];
      if (reg_we && hit_ncoef) ncoef_q  <= NC_W'(wdata);
      if (reg_we && hit_nsamp) nsamp_q  <= SAMP_W'(wdata);
      // A done pulse coinciding with the clear keeps DONE set.
      done_q <= done | (done_q & ~(reg_we & hit_stat & PWDATA[1]));
      irq_q  <= irq_en_q & done_q;
    end
  end

  always_ff @(posedge PCLK) begin
    if (coef_we && !PRESET) mem[apb_idx] <= wdata[DATA_W-1:0];
    ram_q <= mem[ram_raddr];
  end

  // APB outputs are combinational, so force them to their reset values while PRESET is high.
  assign PREADY        = pready_c & ~PRESET;
  assign PSLVERR       = pslverr_c & ~PRESET;
  assign PRDATA        = PRESET ? 32'd0 : prdata_c;
  assign start         = start_q;
  assign irq           = irq_q;
  assign fir_coef_data = ram_q;
  assign num_coef      = ncoef_q;
  assign num_samples   = nsamp_q;

endmodule

// File: tb/tb_apb_fir_ctrl_slave.sv
// Bench for apb_fir_ctrl_slave: a cycle model of the register map checked every cycle,
// plus directed APB sequences with hand-computed expectations.
module tb_apb_fir_ctrl_slave;
  localparam int DATA_W = 16, NUM_COEF = 32, SAMP_W = 14, CA_W = 5;

  logic              PCLK = 1'b0;
  logic              PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0]       PADDR, PWDATA;
  logic              PREADY, PSLVERR;
  logic [31:0]       PRDATA;
  logic              start, busy, done, irq;
  logic [CA_W-1:0]   fir_coef_addr;
  logic [DATA_W-1:0] fir_coef_data;
  logic [CA_W:0]     num_coef;
  logic [SAMP_W-1:0] num_samples;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  apb_fir_ctrl_slave #(.DATA_W(DATA_W), .NUM_COEF(NUM_COEF), .SAMP_W(SAMP_W)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .start(start), .busy(busy), .done(done), .irq(irq), .fir_coef_addr(fir_coef_addr),
    .fir_coef_data(fir_coef_data), .num_coef(num_coef), .num_samples(num_samples));

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_coef [NUM_COEF];
  bit          m_valid [NUM_COEF];
  bit          m_irq_en, m_done, exp_start, exp_irq, prev_busy;
  int          m_ncoef, m_nsamp, acc_cnt, prev_fir, idx;
  bit          acc, is_coef, mapped, err, exp_rdy, w_ok, w1c;
  logic [31:0] wd, exp_rd;

  initial foreach (m_valid[i]) m_valid[i] = 0;

  always @(negedge PCLK) begin
    if (PRESET) begin
      chk("rst_pready", PREADY, 0);
      chk("rst_pslverr", PSLVERR, 0);
      chk("rst_prdata", PRDATA, 0);
      chk("rst_start", start, 0);
      chk("rst_irq", irq, 0);
      chk("rst_num_coef", num_coef, 0);
      chk("rst_num_samples", num_samples, 0);
      m_irq_en = 0; m_done = 0; m_ncoef = 0; m_nsamp = 0;
      exp_start = 0; exp_irq = 0; acc_cnt = 0; prev_busy = 0;
    end else begin
      acc     = PSEL && PENABLE;
      wd      = PWDATA & 32'hFFFF;
      is_coef = (PADDR >= 32'h100) && (PADDR < 32'h100 + 4 * NUM_COEF) && (PADDR % 4 == 0);
      idx     = is_coef ? int'((PADDR - 32'h100) / 4) : 0;
      mapped  = is_coef || PADDR == 0 || PADDR == 4 || PADDR == 8 || PADDR == 12;
      err = acc && (!mapped || (is_coef && busy) || (PWRITE && PADDR == 0 && PWDATA[0] && busy)
                    || (PWRITE && PADDR == 8 && wd > NUM_COEF));
      if (!acc)                        exp_rdy = 0;
      else if (err)                    exp_rdy = 1;
      else if (is_coef && !PWRITE)     exp_rdy = (acc_cnt >= 1);
      else                             exp_rdy = 1;

      chk("pready", PREADY, exp_rdy);
      if (exp_rdy) begin
        chk("pslverr", PSLVERR, err);
        if (!PWRITE) begin
          exp_rd = 0;
          if (!err) begin
            if (PADDR == 0)       exp_rd = {30'd0, m_irq_en, 1'b0};
            else if (PADDR == 4)  exp_rd = {30'd0, m_done, busy};
            else if (PADDR == 8)  exp_rd = m_ncoef;
            else if (PADDR == 12) exp_rd = m_nsamp;
            else                  exp_rd = {16'd0, m_coef[idx]};
          end
          if (!(is_coef && !err && !m_valid[idx])) chk("prdata", PRDATA, exp_rd);
        end
      end
      chk("start", start, exp_start);
      chk("irq", irq, exp_irq);
      chk("num_coef", num_coef, m_ncoef);
      chk("num_samples", num_samples, m_nsamp);
      if (prev_busy && m_valid[prev_fir]) chk("fir_coef_data", fir_coef_data, m_coef[prev_fir]);

      exp_irq   = m_irq_en && m_done;
      w_ok      = exp_rdy && !err && PWRITE;
      exp_start = w_ok && PADDR == 0 && PWDATA[0];
      w1c       = w_ok && PADDR == 4 && PWDATA[1];
      m_done    = done || (m_done && !w1c);
      if (w_ok) begin
        if (PADDR == 0)       m_irq_en = PWDATA[1];
        else if (PADDR == 8)  m_ncoef = wd;
        else if (PADDR == 12) m_nsamp = PWDATA & 32'h3FFF;
        else if (is_coef) begin
          m_coef[idx]  = wd[15:0];
          m_valid[idx] = 1;
        end
      end
      acc_cnt   = (acc && !exp_rdy) ? acc_cnt + 1 : 0;
      prev_busy = busy;
      prev_fir  = fir_coef_addr;
    end
  end

  always @(negedge PCLK) if (start === 1'b1) start_cnt++;

  // ---------------- APB driver ----------------
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                     input bit pulse_done, output logic [31:0] rd, output logic er,
                     output int waits);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wdat;
    @(posedge PCLK); #1;
    PENABLE = 1;
    if (pulse_done) done = 1;
    waits = 0; rd = 0; er = 0;
    forever begin
      @(negedge PCLK);
      if (PREADY) begin
        rd = PRDATA; er = PSLVERR;
        break;
      end
      waits++;
      if (waits > 4) begin
        chk("apb_timeout", waits, 0);
        break;
      end
    end
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; done = 0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          w;

  initial begin
    PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    busy = 0; done = 0; fir_coef_addr = 0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 0;

    // 1: registers read zero, no wait states
    for (int a = 0; a < 16; a += 4) begin
      apb(0, a, 0, 0, rd, er, w);
      chk("t1_rdata", rd, 0);
      chk("t1_err", er, 0);
      chk("t1_waits", w, 0);
    end

    // 2: coefficient write/read, one wait state, upper PWDATA bits ignored
    apb(1, 32'h114, 32'hABCD_1234, 0, rd, er, w);
    chk("t2_wr_waits", w, 0);
    apb(0, 32'h114, 0, 0, rd, er, w);
    chk("t2_rd5", rd, 32'h1234);
    chk("t2_rd5_waits", w, 1);
    apb(1, 32'h17C, 32'h0F0F, 0, rd, er, w);
    apb(0, 32'h17C, 0, 0, rd, er, w);
    chk("t2_rd31", rd, 32'h0F0F);
    chk("t2_rd31_waits", w, 1);
    apb(1, 32'h10C, 32'h0BEE, 0, rd, er, w);

    // 3: busy blocks APB coefficient access; FIR side reads the RAM
    busy = 1; fir_coef_addr = 5;
    apb(1, 32'h10C, 32'h5555, 0, rd, er, w);
    chk("t3_wr_busy_err", er, 1);
    chk("t3_wr_busy_waits", w, 0);
    apb(0, 32'h200, 0, 0, rd, er, w);
    chk("t3_unmapped_err", er, 1);
    chk("t3_unmapped_rdata", rd, 0);
    apb(0, 32'h114, 0, 0, rd, er, w);
    chk("t3_rd_busy_err", er, 1);
    apb(1, 32'h0, 32'h1, 0, rd, er, w);
    chk("t3_start_busy_err", er, 1);
    @(negedge PCLK);
    chk("t3_fir_data", fir_coef_data, 32'h1234);
    busy = 0;
    apb(0, 32'h10C, 0, 0, rd, er, w);
    chk("t3_coef3_kept", rd, 32'h0BEE);
    chk("t3_no_start", start_cnt, 0);

    // 4: start pulse, done -> DONE/irq, W1C clears
    apb(1, 32'h0, 32'h3, 0, rd, er, w);
    chk("t4_ctrl_err", er, 0);
    repeat (4) @(negedge PCLK);
    chk("t4_start_cnt", start_cnt, 1);
    @(posedge PCLK); #1 done = 1;
    @(posedge PCLK); #1 done = 0;
    apb(0, 32'h4, 0, 0, rd, er, w);
    chk("t4_status", rd, 32'h2);
    chk("t4_irq_set", irq, 1);
    apb(1, 32'h4, 32'h2, 0, rd, er, w);
    repeat (2) @(negedge PCLK);
    chk("t4_irq_clr", irq, 0);
    apb(0, 32'h4, 0, 0, rd, er, w);
    chk("t4_status_clr", rd, 32'h0);

    // 5: done wins over simultaneous W1C; NUM_COEF range check
    apb(1, 32'h4, 32'h2, 1, rd, er, w);
    apb(0, 32'h4, 0, 0, rd, er, w);
    chk("t5_done_kept", rd, 32'h2);
    apb(1, 32'h8, 32'd20, 0, rd, er, w);
    chk("t5_nc20_err", er, 0);
    apb(1, 32'h8, 32'd33, 0, rd, er, w);
    chk("t5_nc33_err", er, 1);
    apb(0, 32'h8, 0, 0, rd, er, w);
    chk("t5_nc_kept", rd, 32'd20);
    apb(1, 32'h8, 32'd32, 0, rd, er, w);
    chk("t5_nc32_err", er, 0);
    apb(1, 32'hC, 32'h3ABC, 0, rd, er, w);
    apb(0, 32'hC, 0, 0, rd, er, w);
    chk("t5_nsamp", rd, 32'h3ABC);

    // 6: reset during the read wait state
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 32'h114;
    @(posedge PCLK); #1 PENABLE = 1;
    @(posedge PCLK); #1 PRESET = 1;
    @(negedge PCLK);
    chk("t6_pready_rst", PREADY, 0);
    @(posedge PCLK); #1;
    PRESET = 0; PSEL = 0; PENABLE = 0;
    apb(0, 32'h0, 0, 0, rd, er, w);
    chk("t6_ctrl", rd, 0);
    apb(0, 32'h8, 0, 0, rd, er, w);
    chk("t6_ncoef", rd, 0);
    chk("t6_irq", irq, 0);
    apb(0, 32'h114, 0, 0, rd, er, w);
    chk("t6_rd5", rd, 32'h1234);
    chk("t6_rd5_waits", w, 1);

    repeat (2) @(negedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
